// File: rtl/ysyx_22040125_mem_lsu.sv
// Memory-access stage: issues data-memory requests, aligns and extends load
// data, stalls while an access is in flight, passes ALU results straight through.
module ysyx_22040125_mem_lsu #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_alu_res,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_fault,
  output logic            stall,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wmask,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_rdata
);

  localparam int unsigned OFFW = 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_mem;
  logic              misaligned;
  logic              fault;
  logic [7:0]        size_mask;

  // Shift the addressed bytes down to bit 0, then sign/zero-extend by size.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                               input logic [2:0] f3,
                                               input logic [OFFW-1:0] off);
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  load_ext = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b011:  load_ext = sh;
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: load_ext = '0;
    endcase
  endfunction

  // Access decode: size mask and alignment check of the incoming instruction.
  always_comb begin
    is_mem     = in_valid & (in_load | in_store);
    size_mask  = 8'h01;
    misaligned = 1'b0;
    case (in_funct3[1:0])
      2'b00: size_mask = 8'h01;
      2'b01: begin size_mask = 8'h03; misaligned = in_addr[0];      end
      2'b10: begin size_mask = 8'h0F; misaligned = |in_addr[1:0];   end
      2'b11: begin size_mask = 8'hFF; misaligned = |in_addr[2:0];   end
      default: ;
    endcase
    fault = misaligned | (in_funct3 == 3'b111);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    result_d       = result_q;
    out_valid      = 1'b0;
    out_result     = '0;
    out_fault      = 1'b0;
    stall          = 1'b0;
    dmem_req_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!is_mem) begin
          out_valid  = in_valid;
          out_result = in_alu_res;
        end else if (fault) begin
          out_valid = 1'b1;
          out_fault = 1'b1;
        end else begin
          stall    = 1'b1;
          we_d     = in_store;
          addr_d   = {in_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          wdata_d  = in_wdata << {in_addr[OFFW-1:0], 3'b000};
          wmask_d  = size_mask << in_addr[OFFW-1:0];
          funct3_d = in_funct3;
          off_d    = in_addr[OFFW-1:0];
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        dmem_req_valid = 1'b1;
        stall          = 1'b1;
        if (dmem_req_ready) begin
          if (dmem_resp_valid) begin
            result_d = we_q ? '0 : load_ext(dmem_resp_rdata, funct3_q, off_q);
            state_d  = S_DONE;
          end else begin
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem_resp_valid) begin
          result_d = we_q ? '0 : load_ext(dmem_resp_rdata, funct3_q, off_q);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        out_valid  = 1'b1;
        out_result = result_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset must silence the combinational outputs immediately, not at the next edge.
    if (!rst) begin
      out_valid      = 1'b0;
      out_result     = '0;
      out_fault      = 1'b0;
      stall          = 1'b0;
      dmem_req_valid = 1'b0;
    end
  end

  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_wmask = wmask_q;

endmodule

// File: doc/ysyx_22040125_mem_lsu.md
Name: ysyx_22040125_mem_lsu

Overview:
Memory-access stage of the RV64 pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register (MEM_REG).
- Issues load/store requests to the data-memory port with a valid/ready request and a response handshake.
- Aligns and sign/zero-extends load data.
- Stalls the pipeline while an access is outstanding.
- Non-memory instructions pass straight through with zero latency.

Parameters:
XLEN, 64, data/address width; the lane logic below is written for 64 (8 byte lanes).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  instruction present from EX/MEM
in_load  in  1  instruction is a load
in_store  in  1  instruction is a store (in_load and in_store never both 1)
in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
in_addr  in  64  effective address
in_wdata  in  64  store data, right-justified
in_alu_res  in  64  ALU result for non-memory instructions
out_valid  out  1  result valid to MEM_REG this cycle
out_result  out  64  writeback value
out_fault  out  1  misaligned access or illegal funct3; no bus access made
stall  out  1  holds all upstream stages and MEM_REG
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1 = store
dmem_req_addr  out  64  in_addr with bits [2:0] forced to 0
dmem_req_wdata  out  64  store data shifted to its byte lane
dmem_req_wmask  out  8  byte enables
dmem_resp_valid  in  1  response (load data or store acknowledge)
dmem_resp_rdata  in  64  aligned 64-bit read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset enters IDLE asynchronously.
- Reset values: dmem_req_* all 0; out_valid 0; out_result 0; out_fault 0; stall 0; all internal registers 0.
- IDLE, no memory op (in_valid=0, or neither load nor store):
  - out_valid=in_valid, out_result=in_alu_res, stall=0. Combinational, zero cycles.
- IDLE, memory op with fault: fault = misaligned (H: addr[0]!=0; W/WU: addr[1:0]!=0; D: addr[2:0]!=0) or funct3=111.
  - out_valid=1, out_fault=1, out_result=0, stall=0.
  - No request issued; stay in IDLE.
- IDLE, legal memory op:
  - stall=1, out_valid=0.
  - Register we, aligned address, lane-shifted wdata, wmask, funct3 and addr[2:0].
  - Next state REQ.
- Lanes:
  - wmask = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) << addr[2:0].
  - wdata = in_wdata << (8*addr[2:0]).
  - For loads, wmask and wdata are still driven but ignored by memory.
- REQ:
  - dmem_req_valid=1, stall=1.
  - Request fields stay stable until the cycle where dmem_req_valid && dmem_req_ready, then go to WAIT.
  - Same-cycle response: if dmem_resp_valid is also 1 in that cycle, capture it and go directly to DONE.
- WAIT:
  - dmem_req_valid=0, stall=1.
  - On dmem_resp_valid, capture the result and go to DONE.
- Load result: dmem_resp_rdata >> (8*addr[2:0]), then:
  - B/H/W: sign-extend from bit 7/15/31.
  - BU/HU/WU: zero-extend.
  - D: take all 64 bits.
- Store result: out_result=0.
- DONE:
  - out_valid=1, out_result=captured value, out_fault=0, stall=0.
  - Always lasts exactly one cycle, then IDLE.
  - in_* are not examined in DONE; the next instruction is handled in the following IDLE cycle.
- Latency: minimum 3 cycles from an IDLE accept to DONE (IDLE → REQ → WAIT/DONE).
- dmem_resp_valid while in IDLE or DONE: ignored. This covers stale responses after a reset mid-access.
- Upstream contract: in_* are held stable while stall=1.
- Reset mid-operation (any state):
  - Immediate return to IDLE.
  - dmem_req_valid and stall drop asynchronously.
  - No out_valid for the aborted instruction.

Test Plan:
- ALU op passthrough: in_valid=1, in_load=in_store=0, in_alu_res=0x1234 → same cycle out_valid=1, out_result=0x1234, stall=0, dmem_req_valid=0.
- LB with sign extension: addr=0x1003, resp_rdata=0x00000000_80000000, ready=1 on first REQ cycle, resp one cycle later → DONE out_result=0xFFFFFFFF_FFFFFF80. Stall high exactly 3 cycles.
- LWU/LW on the same data: addr=0x1004, rdata=0x89ABCDEF_00000000 → LWU gives 0x00000000_89ABCDEF; LW gives 0xFFFFFFFF_89ABCDEF.
- SH with backpressure: addr=0x2006, wdata=0xBEEF, ready held 0 for 4 cycles → req_addr=0x2000, wmask=0xC0, wdata=0xBEEF0000_00000000, all stable while waiting. DONE follows the response with out_result=0.
- Misaligned LD at addr=0x3004 → same cycle out_fault=1, out_valid=1, stall=0, no dmem_req_valid ever. funct3=111 gives the same response.
- Reset asserted in WAIT → req_valid/stall drop immediately. A dmem_resp_valid arriving after release is ignored, and no out_valid is produced.
